// File: rtl/fp_align_extend.sv
// fp_align_extend: two-stage operand alignment for the FPU adder.
// Stage 1 orders the operands by effective exponent. Stage 2 right-shifts the
// smaller significand (with guard/round/sticky) and emits both significands as
// sign-extended two's-complement words. A valid/ready handshake links the stages.
`timescale 1ns/1ps
module fp_align_extend #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    a_sign,
    input  logic                    b_sign,
    input  logic [EXP_W-1:0]        a_exp,
    input  logic [EXP_W-1:0]        b_exp,
    input  logic [MAN_W-1:0]        a_man,
    input  logic [MAN_W-1:0]        b_man,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [MAN_W+4:0] big_ext,
    output logic signed [MAN_W+4:0] small_ext,
    output logic [EXP_W-1:0]        exp_out,
    output logic                    swapped
);

    localparam int OUT_W  = MAN_W + 5;
    // Shift distance at which the whole window (hidden + fraction + GRS) is gone.
    localparam int SAT_SH = MAN_W + 4;

    // Window {0, hidden, man, 000} shifted right by sh; everything that falls
    // off the bottom is ORed into bit 0 as the sticky bit.
    function automatic logic [OUT_W-1:0] align_small(input logic [MAN_W:0] mag,
                                                     input logic [EXP_W-1:0] sh);
        logic [2*OUT_W-1:0] w_wide;
        logic [OUT_W-1:0]   w_res;
        w_wide = '0;
        if (int'(sh) >= SAT_SH) begin
            w_res = {{(OUT_W-1){1'b0}}, |mag};
        end else begin
            w_wide   = {1'b0, mag, 3'b000, {OUT_W{1'b0}}} >> sh;
            w_res    = w_wide[2*OUT_W-1:OUT_W];
            w_res[0] = w_res[0] | (|w_wide[OUT_W-1:0]);
        end
        return w_res;
    endfunction

    // Apply the operand sign; a negative zero magnitude wraps back to 0.
    function automatic logic signed [OUT_W-1:0] to_twos(input logic neg,
                                                       input logic [OUT_W-1:0] mag);
        logic signed [OUT_W-1:0] w_mag;
        w_mag = $signed(mag);
        return neg ? -w_mag : w_mag;
    endfunction

    // Control
    logic w_s2_load;
    logic w_in_fire;

    // Stage 1 combinational compare/swap
    logic             w_hid_a, w_hid_b;
    logic [EXP_W-1:0] w_eff_a, w_eff_b;
    logic             w_swap;
    logic             w_big_sign, w_small_sign;
    logic [MAN_W:0]   w_big_mag, w_small_mag;
    logic [EXP_W-1:0] w_big_exp, w_small_exp;

    // Stage 1 registers
    logic             r_vld_p1;
    logic             r_big_sign_p1, r_small_sign_p1;
    logic [MAN_W:0]   r_big_mag_p1, r_small_mag_p1;
    logic [EXP_W-1:0] r_exp_p1, r_diff_p1;
    logic             r_swap_p1;

    // Stage 2 combinational align/extend
    logic signed [OUT_W-1:0] w_big_p2, w_small_p2;

    // Stage 2 registers
    logic                    r_vld_p2;
    logic signed [OUT_W-1:0] r_big_p2, r_small_p2;
    logic [EXP_W-1:0]        r_exp_p2;
    logic                    r_swap_p2;

    assign w_s2_load = !r_vld_p2 || out_ready;
    assign in_ready  = !r_vld_p1 || w_s2_load;
    assign w_in_fire = in_valid && in_ready;

    assign w_hid_a = |a_exp;
    assign w_hid_b = |b_exp;
    assign w_eff_a = w_hid_a ? a_exp : EXP_W'(1);
    assign w_eff_b = w_hid_b ? b_exp : EXP_W'(1);
    assign w_swap  = w_eff_b > w_eff_a;

    // Route operands into big/small slots; ties keep A as the big operand.
    always_comb begin
        w_big_sign   = a_sign;
        w_small_sign = b_sign;
        w_big_mag    = {w_hid_a, a_man};
        w_small_mag  = {w_hid_b, b_man};
        w_big_exp    = w_eff_a;
        w_small_exp  = w_eff_b;
        if (w_swap) begin
            w_big_sign   = b_sign;
            w_small_sign = a_sign;
            w_big_mag    = {w_hid_b, b_man};
            w_small_mag  = {w_hid_a, a_man};
            w_big_exp    = w_eff_b;
            w_small_exp  = w_eff_a;
        end
    end

    // ---- stage 0 -> stage 1 boundary ----
    // Stage 1 valid: refills (or empties) whenever the block is ready for input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1 <= 1'b0;
        end else if (in_ready) begin
            r_vld_p1 <= in_valid;
        end
    end

    // Stage 1 data: captured only on an accepted input pair.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_big_sign_p1   <= w_big_sign;
            r_small_sign_p1 <= w_small_sign;
            r_big_mag_p1    <= w_big_mag;
            r_small_mag_p1  <= w_small_mag;
            r_exp_p1        <= w_big_exp;
            r_diff_p1       <= w_big_exp - w_small_exp;
            r_swap_p1       <= w_swap;
        end
    end

    assign w_big_p2   = to_twos(r_big_sign_p1, {1'b0, r_big_mag_p1, 3'b000});
    assign w_small_p2 = to_twos(r_small_sign_p1, align_small(r_small_mag_p1, r_diff_p1));

    // ---- stage 1 -> stage 2 boundary ----
    // Output stage: cleared on reset, advances only when downstream can take it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p2   <= 1'b0;
            r_big_p2   <= '0;
            r_small_p2 <= '0;
            r_exp_p2   <= '0;
            r_swap_p2  <= 1'b0;
        end else if (w_s2_load) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_big_p2   <= w_big_p2;
                r_small_p2 <= w_small_p2;
                r_exp_p2   <= r_exp_p1;
                r_swap_p2  <= r_swap_p1;
            end
        end
    end

    assign out_valid = r_vld_p2;
    assign big_ext   = r_big_p2;
    assign small_ext = r_small_p2;
    assign exp_out   = r_exp_p2;
    assign swapped   = r_swap_p2;

endmodule

// File: tb/tb_fp_align_extend.sv
// Testbench for fp_align_extend: scoreboard of expected results pushed on
// accepted input pairs and popped when the DUT transfers a result out.
`timescale 1ns/1ps
module tb_fp_align_extend;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int OUT_W = MAN_W + 5;

    typedef struct packed {
        logic             a_sign;
        logic [EXP_W-1:0] a_exp;
        logic [MAN_W-1:0] a_man;
        logic             b_sign;
        logic [EXP_W-1:0] b_exp;
        logic [MAN_W-1:0] b_man;
    } op_t;

    typedef struct packed {
        logic             sw;
        logic [EXP_W-1:0] ex;
        logic [OUT_W-1:0] sm;
        logic [OUT_W-1:0] bg;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, swapped;
    logic signed [OUT_W-1:0] big_ext, small_ext;
    logic [EXP_W-1:0] exp_out;
    op_t  cur = '0;
    res_t cur_exp = '0;

    res_t sb[$];
    int errors = 0;
    int checks = 0;

    fp_align_extend #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_sign(cur.a_sign), .b_sign(cur.b_sign),
        .a_exp(cur.a_exp), .b_exp(cur.b_exp),
        .a_man(cur.a_man), .b_man(cur.b_man),
        .out_valid(out_valid), .out_ready(out_ready),
        .big_ext(big_ext), .small_ext(small_ext),
        .exp_out(exp_out), .swapped(swapped)
    );

    always #5 clk = ~clk;

    function automatic op_t mk(input logic sa, input int ea, input int ma,
                               input logic sb_, input int eb, input int mb);
        op_t o;
        o.a_sign = sa; o.a_exp = EXP_W'(ea); o.a_man = MAN_W'(ma);
        o.b_sign = sb_; o.b_exp = EXP_W'(eb); o.b_man = MAN_W'(mb);
        return o;
    endfunction

    function automatic logic [OUT_W-1:0] signed_word(input logic n, input longint m);
        longint t;
        longint modv;
        modv = longint'(1) << OUT_W;
        t = n ? (modv - m) : m;
        if (t >= modv) t = t - modv;
        return t[OUT_W-1:0];
    endfunction

    // Arithmetic reference: integer significands, bit-by-bit shift with sticky.
    function automatic res_t model(input op_t o);
        res_t   r;
        longint fa, fb, mb, ms, v;
        int     ea, eb, ebig, esml, d;
        logic   nb, ns, st;
        ea = (o.a_exp == 0) ? 1 : int'(o.a_exp);
        eb = (o.b_exp == 0) ? 1 : int'(o.b_exp);
        fa = ((o.a_exp != 0) ? (longint'(1) << MAN_W) : 0) + longint'(o.a_man);
        fb = ((o.b_exp != 0) ? (longint'(1) << MAN_W) : 0) + longint'(o.b_man);
        if (eb > ea) begin
            r.sw = 1'b1; mb = fb; ms = fa; ebig = eb; esml = ea; nb = o.b_sign; ns = o.a_sign;
        end else begin
            r.sw = 1'b0; mb = fa; ms = fb; ebig = ea; esml = eb; nb = o.a_sign; ns = o.b_sign;
        end
        mb = mb * 8;
        v  = ms * 8;
        d  = ebig - esml;
        st = 1'b0;
        for (int i = 0; i < d; i++) begin
            st = st | v[0];
            v  = v >> 1;
        end
        if (st) v = v | 1;
        r.bg = signed_word(nb, mb);
        r.sm = signed_word(ns, v);
        r.ex = EXP_W'(ebig);
        return r;
    endfunction

    // One clock: sample handshakes at negedge, push expected on accept, return to posedge+1.
    task automatic tick(output logic took, output logic fired, output res_t act);
        @(negedge clk);
        took  = in_valid && in_ready && !reset;
        fired = out_valid && out_ready && !reset;
        act   = {swapped, exp_out, small_ext, big_ext};
        if (took) sb.push_back(cur_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if ({swapped, exp_out, small_ext, big_ext} !== '0) begin
            errors++; $display("FAIL reset_outputs got=%h want=0", {swapped, exp_out, small_ext, big_ext});
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_latency();
        logic took, fired; res_t act, e;
        out_ready = 1'b1;
        cur = mk(0, 127, 0, 0, 127, 0);
        cur_exp = {1'b0, 8'd127, 28'h4000000, 28'h4000000};
        in_valid = 1'b1;
        tick(took, fired, act);
        in_valid = 1'b0;
        checks++;
        if (took !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL lat_stage1 took=%b out_valid=%b want took=1 out_valid=0", took, out_valid);
        end
        tick(took, fired, act);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_stage2 out_valid got=%b want=1", out_valid); end
        tick(took, fired, act);
        if (fired && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (act !== e) begin errors++; $display("FAIL lat_value got=%h want=%h", act, e); end
        end else begin
            checks++; errors++; $display("FAIL lat_output fired=%b want=1", fired);
        end
    endtask

    task automatic test_directed();
        op_t  ops[10];
        res_t exps[10];
        int   idx, cyc;
        logic took, fired; res_t act, e;
        ops[0] = mk(0, 127, 0, 0, 127, 0);             exps[0] = {1'b0, 8'd127, 28'h4000000, 28'h4000000};
        ops[1] = mk(0, 127, 0, 1, 126, 0);             exps[1] = {1'b0, 8'd127, 28'hE000000, 28'h4000000};
        ops[2] = mk(0, 126, 0, 1, 127, 0);             exps[2] = {1'b1, 8'd127, 28'h2000000, 28'hC000000};
        ops[3] = mk(0, 127, 0, 0, 100, 1);             exps[3] = {1'b0, 8'd127, 28'h0000001, 28'h4000000};
        ops[4] = mk(0, 127, 0, 0, 124, 1);             exps[4] = {1'b0, 8'd127, 28'h0800001, 28'h4000000};
        ops[5] = mk(0, 127, 0, 0, 123, 1);             exps[5] = {1'b0, 8'd127, 28'h0400001, 28'h4000000};
        ops[6] = mk(0, 0, 5, 0, 0, 3);                 exps[6] = {1'b0, 8'd1,   28'h0000018, 28'h0000028};
        ops[7] = mk(1, 0, 0, 0, 1, 0);                 exps[7] = {1'b0, 8'd1,   28'h4000000, 28'h0000000};
        ops[8] = mk(1, 120, 'h7FFFFF, 0, 130, 0);      exps[8] = {1'b1, 8'd130, 28'hFFE0001, 28'h4000000};
        ops[9] = mk(0, 130, 1, 1, 130, 'h400000);      exps[9] = {1'b0, 8'd130, 28'hA000000, 28'h4000008};
        out_ready = 1'b1;
        idx = 0; cyc = 0;
        cur = ops[0]; cur_exp = exps[0]; in_valid = 1'b1;
        while ((idx < 10 || sb.size() > 0) && cyc < 100) begin
            tick(took, fired, act);
            cyc++;
            if (fired) begin
                e = sb.pop_front();
                checks++;
                if (act !== e) begin errors++; $display("FAIL directed got=%h want=%h", act, e); end
            end
            if (took) begin
                idx++;
                if (idx < 10) begin cur = ops[idx]; cur_exp = exps[idx]; end
                else in_valid = 1'b0;
            end
        end
        if (cyc >= 100) begin checks++; errors++; $display("FAIL directed_timeout left=%0d want=0", sb.size()); end
    endtask

    task automatic test_random();
        int   sent, cyc, ea;
        logic took, fired; res_t act, e;
        op_t  o;
        sent = 0; cyc = 0;
        in_valid = 1'b0;
        while ((sent < 60 || sb.size() > 0) && cyc < 2000) begin
            if (!in_valid && sent < 60) begin
                ea = int'($urandom_range(0, 255));
                o = mk(1'($urandom_range(0, 1)), ea, int'($urandom_range(0, 32'h7FFFFF)),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255))
                                                   : ((ea + int'($urandom_range(0, 40)) - 20) & 255),
                       int'($urandom_range(0, 32'h7FFFFF)));
                cur = o; cur_exp = model(o);
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick(took, fired, act);
            cyc++;
            if (fired) begin
                e = sb.pop_front();
                checks++;
                if (act !== e) begin errors++; $display("FAIL random got=%h want=%h", act, e); end
            end
            if (took) begin sent++; in_valid = 1'b0; end
        end
        in_valid = 1'b0;
        if (cyc >= 2000) begin checks++; errors++; $display("FAIL random_timeout sent=%0d left=%0d", sent, sb.size()); end
    endtask

    task automatic test_back_to_back();
        op_t  ops[3];
        int   idx, outs, cyc;
        logic took, fired; res_t act, e;
        logic [OUT_W-1:0] held;
        ops[0] = mk(0, 127, 0, 0, 127, 0);
        ops[1] = mk(0, 127, 0, 1, 126, 0);
        ops[2] = mk(0, 126, 0, 1, 127, 0);
        out_ready = 1'b0;
        idx = 0;
        cur = ops[0]; cur_exp = model(ops[0]); in_valid = 1'b1;
        repeat (5) begin
            tick(took, fired, act);
            if (took) begin
                idx++;
                if (idx < 3) begin cur = ops[idx]; cur_exp = model(ops[idx]); end
            end
        end
        checks++;
        if (idx !== 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_stall accepted=%0d in_ready=%b out_valid=%b want 2/0/1", idx, in_ready, out_valid);
        end
        held = big_ext;
        repeat (2) tick(took, fired, act);
        checks++;
        if (big_ext !== held || out_valid !== 1'b1 || took !== 1'b0) begin
            errors++; $display("FAIL b2b_hold big=%h want=%h out_valid=%b took=%b", big_ext, held, out_valid, took);
        end
        out_ready = 1'b1;
        outs = 0; cyc = 0;
        while (outs < 3 && cyc < 20) begin
            tick(took, fired, act);
            cyc++;
            if (took) begin idx++; in_valid = 1'b0; end
            if (fired) begin
                outs++;
                e = sb.pop_front();
                checks++;
                if (act !== e) begin errors++; $display("FAIL b2b_order got=%h want=%h", act, e); end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (cyc !== 3 || outs !== 3) begin
            errors++; $display("FAIL b2b_drain cycles=%0d outs=%0d want 3/3", cyc, outs);
        end
    endtask

    task automatic test_reset_midflight();
        int   idx, cyc, outs;
        logic took, fired; res_t act;
        out_ready = 1'b0;
        idx = 0; cyc = 0;
        cur = mk(0, 127, 0, 1, 126, 0); cur_exp = model(cur); in_valid = 1'b1;
        while (idx < 2 && cyc < 20) begin
            tick(took, fired, act);
            cyc++;
            if (took) begin idx++; cur = mk(1, 126, 3, 0, 127, 9); cur_exp = model(cur); end
        end
        in_valid = 1'b0;
        tick(took, fired, act);
        checks++;
        if (idx !== 2 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_fill accepted=%0d out_valid=%b in_ready=%b want 2/1/0", idx, out_valid, in_ready);
        end
        reset = 1'b1;
        tick(took, fired, act);
        reset = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {swapped, exp_out, small_ext, big_ext} !== '0) begin
            errors++; $display("FAIL rst_flush out_valid=%b in_ready=%b outs=%h want 0/1/0",
                               out_valid, in_ready, {swapped, exp_out, small_ext, big_ext});
        end
        out_ready = 1'b1;
        outs = 0;
        repeat (5) begin
            tick(took, fired, act);
            if (fired) outs++;
        end
        checks++;
        if (outs !== 0) begin errors++; $display("FAIL rst_stale results=%0d want=0", outs); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midflight();
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL sb_empty left=%0d want=0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
